// File: rtl/pwm_sample_sequencer.sv
// Sample sequencer for the 8-bit pwm block: buffers duty-cycle samples in a FIFO
// and presents one per PWM period, with priming, underrun reporting and graceful stop.
module pwm_sample_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PERIOD      = 256,
  parameter int unsigned PRIME_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [7:0]              in_sample,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    start,
  input  logic                    stop,
  output logic [7:0]              sample,
  output logic                    pwm_en,
  output logic                    busy,
  output logic                    underrun,
  output logic                    underrun_sticky,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(PERIOD);
  localparam int unsigned SW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic            stop_pend_q, stop_pend_d;
  logic [SW-1:0]   sample_q, sample_d;
  logic            en_q, en_d;
  logic            ur_q, ur_d;
  logic            sticky_q, sticky_d;
  logic            busy_q;

  logic [SW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_c, pop_c;
  logic            boundary_c;

  assign in_ready        = (count_q < CW'(DEPTH));
  assign push_c          = in_valid && in_ready;
  assign boundary_c      = (cnt_q == PW'(PERIOD - 1));

  assign sample          = sample_q;
  assign pwm_en          = en_q;
  assign busy            = busy_q;
  assign underrun        = ur_q;
  assign underrun_sticky = sticky_q;
  assign fifo_count      = count_q;

  // Sample storage; contents need no reset since occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= in_sample;
    end
  end

  // FIFO pointers and occupancy; a pop always reads the pre-edge head, so no bypass.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // Playback state and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      sample_q    <= '0;
      en_q        <= 1'b0;
      ur_q        <= 1'b0;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      sample_q    <= sample_d;
      en_q        <= en_d;
      ur_q        <= ur_d;
      sticky_q    <= sticky_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Next-state and output logic; stop outranks start, and a running period always completes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    sample_d    = sample_q;
    en_d        = en_q;
    ur_d        = 1'b0;
    sticky_d    = sticky_q;
    pop_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d        = 1'b0;
        sample_d    = '0;
        cnt_d       = '0;
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d  = ST_PRIME;
          sticky_d = 1'b0;
        end
      end

      ST_PRIME: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (count_q >= CW'(PRIME_LEVEL)) begin
          state_d  = ST_RUN;
          pop_c    = 1'b1;
          sample_d = mem[rd_ptr_q];
          en_d     = 1'b1;
          cnt_d    = '0;
        end
      end

      ST_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (boundary_c) begin
          cnt_d = '0;
          if (stop_pend_q) begin
            state_d     = ST_IDLE;
            en_d        = 1'b0;
            sample_d    = '0;
            stop_pend_d = 1'b0;
          end else if (count_q != '0) begin
            pop_c    = 1'b1;
            sample_d = mem[rd_ptr_q];
          end else begin
            sample_d = '0;
            ur_d     = 1'b1;
            sticky_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Self-checking bench for pwm_sample_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based playback model.
module tb_pwm_sample_sequencer;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned PERIOD      = 256;
  localparam int unsigned PRIME_LEVEL = 2;
  localparam int unsigned CW          = $clog2(DEPTH) + 1;

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic [7:0]    in_sample;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic          stop;
  logic [7:0]    sample;
  logic          pwm_en;
  logic          busy;
  logic          underrun;
  logic          underrun_sticky;
  logic [CW-1:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #50 tb_clk = ~tb_clk;

  pwm_sample_sequencer #(
    .DEPTH(DEPTH), .PERIOD(PERIOD), .PRIME_LEVEL(PRIME_LEVEL)
  ) dut (
    .clk(tb_clk), .n_rst(n_rst),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .stop(stop),
    .sample(sample), .pwm_en(pwm_en), .busy(busy),
    .underrun(underrun), .underrun_sticky(underrun_sticky),
    .fifo_count(fifo_count)
  );

  // Playback model: a sample queue plus absolute edge numbers; a period ends every PERIOD edges after a load.
  logic [7:0] m_q [$];
  bit         m_prime, m_run, m_stop_req, m_en, m_ur, m_sticky;
  logic [7:0] m_sample;
  longint     m_edge, m_load;

  function automatic void model_reset();
    m_q.delete();
    m_prime = 0; m_run = 0; m_stop_req = 0; m_en = 0; m_ur = 0; m_sticky = 0;
    m_sample = 8'd0; m_edge = 0; m_load = 0;
  endfunction

  function automatic void model_edge(bit v, logic [7:0] d, bit st, bit sp);
    bit push;
    push = v && (m_q.size() < DEPTH);
    m_edge++;
    m_ur = 0;
    if (m_run) begin
      if (((m_edge - m_load) % PERIOD) == 0) begin
        if (m_stop_req) begin
          m_run = 0; m_en = 0; m_sample = 8'd0; m_stop_req = 0;
        end else begin
          if (sp) m_stop_req = 1;
          if (m_q.size() > 0) m_sample = m_q.pop_front();
          else begin m_sample = 8'd0; m_ur = 1; m_sticky = 1; end
        end
      end else if (sp) begin
        m_stop_req = 1;
      end
    end else if (m_prime) begin
      if (sp) m_prime = 0;
      else if (m_q.size() >= PRIME_LEVEL) begin
        m_prime = 0; m_run = 1; m_en = 1; m_load = m_edge;
        m_sample = m_q.pop_front();
      end
    end else if (st && !sp) begin
      m_prime = 1; m_sticky = 0;
    end
    if (push) m_q.push_back(d);
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_sample = 8'd0; start = 1'b0; stop = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic push_samples(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_sample = a; tick();
    in_sample = b; tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] exp_v;
    exp_v = {8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    n_rst = 1'b0; in_valid = 1'b0; in_sample = 8'd0; start = 1'b0; stop = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({sample, pwm_en, busy, underrun, underrun_sticky, fifo_count, in_ready} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_values got %h want %h",
               {sample, pwm_en, busy, underrun, underrun_sticky, fifo_count, in_ready}, exp_v);
    end
    n_rst = 1'b1;
    tick();
    n_tests++;
    if ({sample, pwm_en, busy, underrun, underrun_sticky, fifo_count, in_ready} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release got %h want %h",
               {sample, pwm_en, busy, underrun, underrun_sticky, fifo_count, in_ready}, exp_v);
    end
  endtask

  task automatic test_fill();
    int exp_cnt;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sample = 8'(10 * (i + 1));
      tick();
      exp_cnt = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      n_tests++;
      if (fifo_count !== CW'(exp_cnt)) begin
        n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, fifo_count, exp_cnt);
      end
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready);
    end
    in_valid = 1'b0;
    // Drain: the four accepted samples play in order, then the FIFO is empty (50 was dropped).
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (sample !== 8'(10 * (k + 1)) || pwm_en !== 1'b1) begin
        n_fail++; $display("FAIL fill_order[%0d] got %0d/%b want %0d/1", k, sample, pwm_en, 10 * (k + 1));
      end
      repeat (PERIOD) tick();
    end
    n_tests++;
    if (sample !== 8'd0 || underrun !== 1'b1) begin
      n_fail++; $display("FAIL fill_no_fifth got sample %0d ur %b want 0 1", sample, underrun);
    end
  endtask

  task automatic test_playback_and_underrun();
    int bad;
    do_reset();
    push_samples(8'd127, 8'd255);
    n_tests++;
    if (fifo_count !== CW'(2)) begin
      n_fail++; $display("FAIL play_queued got %0d want 2", fifo_count);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || pwm_en !== 1'b0) begin
      n_fail++; $display("FAIL play_prime got busy %b en %b want 1 0", busy, pwm_en);
    end
    tick();
    n_tests++;
    if (pwm_en !== 1'b1 || sample !== 8'd127 || fifo_count !== CW'(1)) begin
      n_fail++; $display("FAIL play_first got en %b sample %0d cnt %0d want 1 127 1", pwm_en, sample, fifo_count);
    end
    bad = 0;
    for (int j = 1; j < PERIOD; j++) begin
      tick();
      if (sample !== 8'd127 || pwm_en !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL play_hold127 got %0d bad cycles want 0", bad);
    end
    tick();
    n_tests++;
    if (sample !== 8'd255 || fifo_count !== CW'(0)) begin
      n_fail++; $display("FAIL play_second got sample %0d cnt %0d want 255 0", sample, fifo_count);
    end
    bad = 0;
    for (int j = 1; j < PERIOD; j++) begin
      tick();
      if (sample !== 8'd255 || underrun !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL play_hold255 got %0d bad cycles want 0", bad);
    end
    tick();
    n_tests++;
    if ({sample, underrun, underrun_sticky, pwm_en} !== {8'd0, 1'b1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL underrun_hit got %h want %h", {sample, underrun, underrun_sticky, pwm_en},
                         {8'd0, 1'b1, 1'b1, 1'b1});
    end
    tick();
    n_tests++;
    if ({underrun, underrun_sticky, pwm_en} !== 3'b011) begin
      n_fail++; $display("FAIL underrun_pulse got %b want 011", {underrun, underrun_sticky, pwm_en});
    end
    stop = 1'b1; tick(); stop = 1'b0;
    bad = 0;
    while (pwm_en === 1'b1 && bad < PERIOD + 4) begin
      tick(); bad++;
    end
    n_tests++;
    if (pwm_en !== 1'b0 || busy !== 1'b0 || underrun_sticky !== 1'b1) begin
      n_fail++; $display("FAIL underrun_stop got en %b busy %b sticky %b want 0 0 1", pwm_en, busy, underrun_sticky);
    end
    push_samples(8'd1, 8'd2);
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (underrun_sticky !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL sticky_clear got sticky %b busy %b want 0 1", underrun_sticky, busy);
    end
  endtask

  task automatic test_stop_mid_period();
    int bad;
    int remain;
    do_reset();
    push_samples(8'd1, 8'd2);
    in_valid = 1'b1; in_sample = 8'd3; tick(); in_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    repeat (100) tick();
    remain = PERIOD - 100;
    bad = 0;
    stop = 1'b1;
    for (int j = 1; j <= remain; j++) begin
      tick();
      stop = 1'b0;
      if (j < remain && (pwm_en !== 1'b1 || sample !== 8'd1)) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL stop_hold got %0d bad cycles want 0", bad);
    end
    n_tests++;
    if ({pwm_en, sample, fifo_count, busy} !== {1'b0, 8'd0, 3'd2, 1'b0}) begin
      n_fail++; $display("FAIL stop_end got %h want %h", {pwm_en, sample, fifo_count, busy},
                         {1'b0, 8'd0, 3'd2, 1'b0});
    end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || pwm_en !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_idle got busy %b en %b want 0 0", busy, pwm_en);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    push_samples(8'd77, 8'd88);
    start = 1'b1; tick(); start = 1'b0; tick();
    repeat (50) tick();
    n_tests++;
    if (pwm_en !== 1'b1 || sample !== 8'd77) begin
      n_fail++; $display("FAIL rstmid_pre got en %b sample %0d want 1 77", pwm_en, sample);
    end
    #20 n_rst = 1'b0;
    #1;
    n_tests++;
    if ({pwm_en, sample, fifo_count, busy, in_ready} !== {1'b0, 8'd0, 3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rstmid_async got %h want %h", {pwm_en, sample, fifo_count, busy, in_ready},
                         {1'b0, 8'd0, 3'd0, 1'b0, 1'b1});
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    model_reset();
    tick();
    n_tests++;
    if (busy !== 1'b0 || pwm_en !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after got busy %b en %b want 0 0", busy, pwm_en);
    end
  endtask

  task automatic test_random();
    bit         c_v, c_st, c_sp;
    logic [7:0] c_d;
    int         rate;
    logic [14:0] exp_v, got_v;
    do_reset();
    rate = 2;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 700 == 0) rate = (rate == 2) ? 400 : 2;
      c_v  = ($urandom_range(0, rate - 1) == 0);
      c_d  = 8'($urandom);
      c_st = ($urandom_range(0, 149) == 0);
      c_sp = ($urandom_range(0, 899) == 0);
      in_valid = c_v; in_sample = c_d; start = c_st; stop = c_sp;
      tick();
      model_edge(c_v, c_d, c_st, c_sp);
      exp_v = {m_sample, m_en, (m_prime || m_run), m_ur, m_sticky, CW'(m_q.size()), (m_q.size() < DEPTH)};
      got_v = {sample, pwm_en, busy, underrun, underrun_sticky, fifo_count, in_ready};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random[%0d] got %h want %h", cyc, got_v, exp_v);
      end
    end
    in_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_playback_and_underrun();
    test_stop_mid_period();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
